// File: rtl/tape_pkg.sv
`default_nettype none
// ============================================================================
// Module   : tape_pkg
// Purpose  : Shared types, defaults and helpers for the tape EAR conditioner.
// Revision : 1.0
// ============================================================================
package tape_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ARM    = 2'd1,
    ACTIVE = 2'd2
  } tape_state_t;

  localparam int DEF_FILT_LEN  = 16;
  localparam int DEF_FILT_W    = 5;
  localparam int DEF_PER_W     = 16;
  localparam int DEF_MIN_EDGES = 8;
  localparam int DEF_IDLE_LEN  = 1000000;
  localparam int DEF_IDLE_W    = 20;

  // Increment that sticks at the all-ones value of a w-bit field.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input int unsigned w);
    logic [31:0] max_v;
    max_v = (w >= 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
    return (v >= max_v) ? max_v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tape_glitch_filter.sv
`default_nettype none
// ============================================================================
// Module   : tape_glitch_filter
// Purpose  : Two-flop synchroniser plus FILT_LEN-sample level filter.
// Revision : 1.0
// ============================================================================
module tape_glitch_filter
  import tape_pkg::*;
#(
  parameter int FILT_LEN = DEF_FILT_LEN,
  parameter int FILT_W   = DEF_FILT_W
) (
  input  logic clock,
  input  logic reset,
  input  logic din,
  input  logic invert,
  output logic level,
  output logic rise
);

  logic              sync1;
  logic              sync2;
  logic              f;
  logic [FILT_W-1:0] cnt;
  logic              at_limit;

  assign at_limit = (cnt == FILT_W'(FILT_LEN - 1));

  // Polarity is folded in ahead of the synchroniser so an invert flip sees
  // the same latency as a data change.
  always_ff @(posedge clock) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      f     <= 1'b0;
      cnt   <= '0;
    end else begin
      sync1 <= din ^ invert;
      sync2 <= sync1;
      if (sync2 == f) begin
        cnt <= '0;
      end else if (at_limit) begin
        f   <= sync2;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign level = f;
  // Strobe asserted in the cycle before level goes 0->1, so the parent can
  // register its edge-related outputs alongside the new level.
  assign rise  = sync2 & ~f & at_limit;

endmodule
`default_nettype wire

// File: rtl/tape_ear_conditioner.sv
`default_nettype none
// ============================================================================
// Module   : tape_ear_conditioner
// Purpose  : Filters the tape comparator bit, measures edge period and gates EAR.
// Revision : 1.0
// ============================================================================
module tape_ear_conditioner
  import tape_pkg::*;
#(
  parameter int FILT_LEN  = DEF_FILT_LEN,
  parameter int FILT_W    = DEF_FILT_W,
  parameter int PER_W     = DEF_PER_W,
  parameter int MIN_EDGES = DEF_MIN_EDGES,
  parameter int IDLE_LEN  = DEF_IDLE_LEN,
  parameter int IDLE_W    = DEF_IDLE_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             adc_din,
  input  logic             adc_act,
  input  logic             invert,
  output logic             ear,
  output logic             ear_edge,
  output logic [PER_W-1:0] period,
  output logic             period_vld,
  output logic             tape_active,
  output logic             led
);

  localparam int EDGE_W = $clog2(MIN_EDGES + 1);

  logic              level;
  logic              rise;
  logic              act_s1;
  logic              act_s2;
  tape_state_t       state;
  logic [PER_W-1:0]  p_cnt;
  logic [IDLE_W-1:0] i_cnt;
  logic [EDGE_W-1:0] e_cnt;

  tape_glitch_filter #(
    .FILT_LEN (FILT_LEN),
    .FILT_W   (FILT_W)
  ) u_filter (
    .clock  (clock),
    .reset  (reset),
    .din    (adc_din),
    .invert (invert),
    .level  (level),
    .rise   (rise)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      act_s1     <= 1'b0;
      act_s2     <= 1'b0;
      ear_edge   <= 1'b0;
      period     <= '0;
      period_vld <= 1'b0;
      state      <= IDLE;
      p_cnt      <= '0;
      i_cnt      <= '0;
      e_cnt      <= '0;
    end else begin
      act_s1     <= adc_act;
      act_s2     <= act_s1;
      ear_edge   <= rise;
      period_vld <= 1'b0;
      // Loss of front-end activity overrides every other transition.
      if (!act_s2) begin
        state <= IDLE;
        p_cnt <= '0;
        i_cnt <= '0;
        e_cnt <= '0;
      end else begin
        if (rise) begin
          p_cnt      <= '0;
          period     <= PER_W'(sat_inc(32'(p_cnt), PER_W));
          period_vld <= (state != IDLE);
        end else begin
          p_cnt <= PER_W'(sat_inc(32'(p_cnt), PER_W));
        end

        case (state)
          IDLE: begin
            if (rise) begin
              state <= ARM;
              e_cnt <= EDGE_W'(1);
              i_cnt <= '0;
            end
          end
          ARM, ACTIVE: begin
            if (rise) begin
              i_cnt <= '0;
              if (state == ARM) begin
                e_cnt <= e_cnt + 1'b1;
                if (e_cnt + 1'b1 == EDGE_W'(MIN_EDGES))
                  state <= ACTIVE;
              end
            end else if (i_cnt == IDLE_W'(IDLE_LEN - 1)) begin
              state <= IDLE;
              e_cnt <= '0;
              i_cnt <= '0;
            end else begin
              i_cnt <= i_cnt + 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

  assign tape_active = (state == ACTIVE);
  assign led         = tape_active;
  assign ear         = level & tape_active;

endmodule
`default_nettype wire
